// File: rtl/mel_frame_sched.sv
// Run-level scheduler around MEL_SPEC: admits one run's worth of samples, then collects
// and tags the mel outputs with frame/band indices and reports done or error status.
module mel_frame_sched #(
  parameter int WIDTH         = 16,
  parameter int N_FRAMES      = 101,
  parameter int WIN_LEN       = 480,
  parameter int HOP_LEN       = 160,
  parameter int MEL_BANDS     = 40,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         src_valid,
  output logic                         src_ready,
  input  logic [WIDTH-1:0]             src_re,
  input  logic [WIDTH-1:0]             src_im,
  output logic                         mel_signal_en,
  output logic [WIDTH-1:0]             mel_signal_re,
  output logic [WIDTH-1:0]             mel_signal_im,
  input  logic                         mel_buf_full,
  input  logic                         mel_avail,
  input  logic [WIDTH-1:0]             mel_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(N_FRAMES)-1:0]  out_frame,
  output logic [$clog2(MEL_BANDS)-1:0] out_band,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout,
  output logic                         err_spurious
);

  localparam int TOTAL_SAMPLES = WIN_LEN + (N_FRAMES - 1) * HOP_LEN;
  localparam int SW = $clog2(TOTAL_SAMPLES + 1);
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int FW = $clog2(N_FRAMES);
  localparam int BW = $clog2(MEL_BANDS);

  localparam logic [SW-1:0] LastSample = SW'(TOTAL_SAMPLES - 1);
  localparam logic [IW-1:0] IdleLimit  = IW'(DRAIN_TIMEOUT - 1);
  localparam logic [FW-1:0] LastFrame  = FW'(N_FRAMES - 1);
  localparam logic [BW-1:0] LastBand   = BW'(MEL_BANDS - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFeed  = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StFlush = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]    band_cnt_q, band_cnt_d;
  logic [FW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             mel_signal_en_d;
  logic [WIDTH-1:0] mel_signal_re_d, mel_signal_im_d;
  logic             out_valid_d, out_last_d;
  logic [WIDTH-1:0] out_data_d;
  logic [FW-1:0]    out_frame_d;
  logic [BW-1:0]    out_band_d;
  logic             done_d, err_timeout_d, err_spurious_d;

  logic xfer, collect, last_mel;

  // Abort removes ready in the same cycle so no sample slips in after cancel.
  assign src_ready = (state_q == StFeed) && !mel_buf_full && !abort;
  assign busy      = (state_q != StIdle);
  assign xfer      = src_valid && src_ready;
  assign collect   = mel_avail && !abort && ((state_q == StFeed) || (state_q == StDrain));
  assign last_mel  = (frame_cnt_q == LastFrame) && (band_cnt_q == LastBand);

  always_comb begin
    state_d         = state_q;
    sample_cnt_d    = sample_cnt_q;
    band_cnt_d      = band_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    idle_cnt_d      = idle_cnt_q;
    mel_signal_en_d = xfer;
    mel_signal_re_d = mel_signal_re;
    mel_signal_im_d = mel_signal_im;
    out_valid_d     = 1'b0;
    out_last_d      = 1'b0;
    out_data_d      = out_data;
    out_frame_d     = out_frame;
    out_band_d      = out_band;
    done_d          = 1'b0;
    err_timeout_d   = err_timeout;
    err_spurious_d  = err_spurious;

    if (xfer) begin
      mel_signal_re_d = src_re;
      mel_signal_im_d = src_im;
    end

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d        = StFeed;
          sample_cnt_d   = '0;
          band_cnt_d     = '0;
          frame_cnt_d    = '0;
          idle_cnt_d     = '0;
          err_timeout_d  = 1'b0;
          err_spurious_d = 1'b0;
        end
        if (mel_avail) err_spurious_d = 1'b1;
      end
      StFeed: begin
        if (abort) begin
          state_d    = StFlush;
          idle_cnt_d = '0;
        end else begin
          if (xfer) begin
            sample_cnt_d = sample_cnt_q + SW'(1);
            if (sample_cnt_q == LastSample) begin
              state_d    = StDrain;
              idle_cnt_d = '0;
            end
          end
          // Final mel value ends the run even if samples are still pending.
          if (collect && last_mel) state_d = StDone;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d    = StFlush;
          idle_cnt_d = '0;
        end else if (mel_avail) begin
          idle_cnt_d = '0;
          if (last_mel) state_d = StDone;
        end else if (idle_cnt_q == IdleLimit) begin
          err_timeout_d = 1'b1;
          state_d       = StDone;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      StDone: begin
        if (mel_avail) err_spurious_d = 1'b1;
        idle_cnt_d = '0;
        if (abort) begin
          state_d = StFlush;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StFlush: begin
        if (mel_avail) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLimit) begin
          state_d = StIdle;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (collect) begin
      out_valid_d = 1'b1;
      out_data_d  = mel_data;
      out_frame_d = frame_cnt_q;
      out_band_d  = band_cnt_q;
      out_last_d  = last_mel;
      if (band_cnt_q == LastBand) begin
        band_cnt_d  = '0;
        frame_cnt_d = frame_cnt_q + FW'(1);
      end else begin
        band_cnt_d = band_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sample_cnt_q  <= '0;
      band_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      mel_signal_en <= 1'b0;
      mel_signal_re <= '0;
      mel_signal_im <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_frame     <= '0;
      out_band      <= '0;
      out_last      <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      band_cnt_q    <= band_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      mel_signal_en <= mel_signal_en_d;
      mel_signal_re <= mel_signal_re_d;
      mel_signal_im <= mel_signal_im_d;
      out_valid     <= out_valid_d;
      out_data      <= out_data_d;
      out_frame     <= out_frame_d;
      out_band      <= out_band_d;
      out_last      <= out_last_d;
      done          <= done_d;
      err_timeout   <= err_timeout_d;
      err_spurious  <= err_spurious_d;
    end
  end

endmodule

// File: tb/tb_mel_frame_sched.sv
// Bench for mel_frame_sched: random-gap MEL_SPEC model feeds a scoreboard of tagged
// mel outputs; run-level scenarios cover throttle, timeout, abort, spurious and reset.
module tb_mel_frame_sched;
  localparam int WIDTH = 16;
  localparam int NF    = 3;
  localparam int WL    = 8;
  localparam int HL    = 4;
  localparam int MB    = 4;
  localparam int DT    = 32;
  localparam int TS    = WL + (NF - 1) * HL;
  localparam int TM    = NF * MB;
  localparam int FW    = $clog2(NF);
  localparam int BW    = $clog2(MB);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0;
  logic             src_valid = 1'b0, src_ready;
  logic [WIDTH-1:0] src_re = '0, src_im = '0;
  logic             mel_signal_en;
  logic [WIDTH-1:0] mel_signal_re, mel_signal_im;
  logic             mel_buf_full = 1'b0, mel_avail = 1'b0;
  logic [WIDTH-1:0] mel_data = '0;
  logic             out_valid, out_last, busy, done, err_timeout, err_spurious;
  logic [WIDTH-1:0] out_data;
  logic [FW-1:0]    out_frame;
  logic [BW-1:0]    out_band;

  always #5 clk = ~clk;

  mel_frame_sched #(
    .WIDTH(WIDTH), .N_FRAMES(NF), .WIN_LEN(WL), .HOP_LEN(HL), .MEL_BANDS(MB),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .src_re(src_re), .src_im(src_im),
    .mel_signal_en(mel_signal_en), .mel_signal_re(mel_signal_re),
    .mel_signal_im(mel_signal_im), .mel_buf_full(mel_buf_full), .mel_avail(mel_avail),
    .mel_data(mel_data), .out_valid(out_valid), .out_data(out_data), .out_frame(out_frame),
    .out_band(out_band), .out_last(out_last), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               frame;
    int               band;
    bit               last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc_n = 0, ov_cnt = 0, done_cnt = 0, last_ov_cyc = 0, done_cyc = 0;
  bit   manual = 1'b0, model_en = 1'b1, model_clr = 1'b0;
  int   mel_limit = TM;
  int   pend = 0, emitted = 0, fwd_cnt = 0, exp_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {4'h0, src_ready, mel_signal_en, mel_signal_re, mel_signal_im, out_valid, out_data,
            out_frame, out_band, out_last, busy, done, err_timeout, err_spurious};
  endfunction

  // Monitor: pops the scoreboard on every tagged output.
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    cyc_n++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (out_valid) begin
      ov_cnt++;
      last_ov_cyc = cyc_n;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got frame %0d band %0d, required none",
                 out_frame, out_band);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_frame", out_frame, mon_e.frame);
        check("out_band", out_band, mon_e.band);
        check("out_last", out_last, mon_e.last);
      end
    end
  end

  // MEL_SPEC model: a frame's MB mel values become available once its window is complete.
  logic [WIDTH-1:0] m_re, m_im;
  exp_t             m_e;
  initial forever begin
    @(negedge clk);
    if (mel_signal_en) begin
      m_re = WIDTH'(fwd_cnt);
      m_im = ~m_re;
      check("fwd_re", mel_signal_re, m_re);
      check("fwd_im", mel_signal_im, m_im);
      fwd_cnt++;
      if (fwd_cnt >= WL && ((fwd_cnt - WL) % HL) == 0) pend += MB;
    end
    @(posedge clk);
    #1;
    if (model_clr) begin
      pend = 0; emitted = 0; fwd_cnt = 0; exp_idx = 0; model_clr = 1'b0;
    end
    if (!manual) begin
      mel_avail = 1'b0;
      if (model_en && pend > 0 && emitted < mel_limit && $urandom_range(0, 3) != 0) begin
        mel_avail = 1'b1;
        mel_data  = WIDTH'($urandom);
        pend--;
        emitted++;
        m_e.data  = mel_data;
        m_e.frame = exp_idx / MB;
        m_e.band  = exp_idx % MB;
        m_e.last  = (exp_idx == TM - 1);
        exp_q.push_back(m_e);
        exp_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_feed(input int limit, input bit hold, input int exp_outs);
    int ov0, dn0, nxt;
    bit fin;
    logic [WIDTH-1:0] ramp;
    mel_limit = limit; manual = 1'b0; model_en = 1'b1; model_clr = 1'b1;
    repeat (3) tick();
    ov0 = ov_cnt; dn0 = done_cnt; nxt = 0; fin = 1'b0;
    start = 1'b1; src_valid = 1'b1; src_re = '0; src_im = '1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
      if (cyc > 1) tick();
      mel_buf_full = hold && cyc >= 5 && cyc <= 9;
      ramp = WIDTH'(nxt);
      src_re = ramp;
      src_im = ~ramp;
      @(negedge clk);
      if (cyc == 1) check("start_clears_err", {err_timeout, err_spurious}, 0);
      if (mel_buf_full) check("ready_while_full", src_ready, 0);
      if (hold && cyc >= 6 && cyc <= 9) check("en_while_full", mel_signal_en, 0);
      if (src_valid && src_ready) nxt++;
      if (!busy) fin = 1'b1;
    end
    src_valid = 1'b0;
    mel_buf_full = 1'b0;
    if (!fin) check("run_timeout", 1, 0);
    repeat (2) @(negedge clk);
    check("out_count", ov_cnt - ov0, exp_outs);
    check("done_count", done_cnt - dn0, 1);
    check("queue_empty", exp_q.size(), 0);
    check("samples_fwd", fwd_cnt, TS);
    if (exp_outs == TM) begin
      check("done_after_last", done_cyc, last_ov_cyc + 1);
      check("err_flags_clean", {err_timeout, err_spurious}, 0);
    end else begin
      check("err_timeout_set", err_timeout, 1);
    end
  endtask

  initial begin
    int n, ov0, dn0, nxt;
    logic [WIDTH-1:0] ramp;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    tick();
    rst = 1'b0;

    run_feed(TM, 1'b0, TM);       // normal run
    run_feed(10, 1'b0, 10);       // model starves: drain timeout
    run_feed(TM, 1'b1, TM);       // buf_full throttle, also clears err_timeout

    // Abort after 7 transfers, late mel values in FLUSH.
    manual = 1'b1; mel_avail = 1'b0; model_clr = 1'b1;
    repeat (3) tick();
    ov0 = ov_cnt; dn0 = done_cnt; nxt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && nxt < 7; cyc++) begin
      if (cyc > 0) tick();
      src_valid = 1'b1;
      ramp = WIDTH'(nxt);
      src_re = ramp;
      src_im = ~ramp;
      @(negedge clk);
      if (src_valid && src_ready) nxt++;
    end
    tick();
    src_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    mel_avail = 1'b1; mel_data = WIDTH'($urandom);
    tick();
    mel_avail = 1'b0;
    repeat (4) tick();
    mel_avail = 1'b1; mel_data = WIDTH'($urandom);
    tick();
    mel_avail = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("flush_busy_cycles", n, DT);
    check("abort_samples", fwd_cnt, 7);
    check("abort_no_out", ov_cnt - ov0, 0);
    check("abort_no_done", done_cnt - dn0, 0);
    run_feed(TM, 1'b0, TM);

    // Spurious mel in IDLE, then start+abort together.
    manual = 1'b1;
    tick();
    mel_avail = 1'b1;
    tick();
    mel_avail = 1'b0;
    @(negedge clk);
    check("spurious_flag", err_spurious, 1);
    check("spurious_no_out", out_valid, 0);
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", busy, 0);
    check("start_abort_flag", err_spurious, 1);

    // Reset while in DRAIN.
    mel_limit = TM; manual = 1'b0; model_en = 1'b1; model_clr = 1'b1;
    repeat (3) tick();
    nxt = 0;
    start = 1'b1; src_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && fwd_cnt < TS; cyc++) begin
      if (cyc > 0) tick();
      ramp = WIDTH'(nxt);
      src_re = ramp;
      src_im = ~ramp;
      @(negedge clk);
      if (src_valid && src_ready) nxt++;
    end
    tick();
    model_en = 1'b0;
    src_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("in_drain_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", all_outs(), 0);
    check("midrun_queue_empty", exp_q.size(), 0);
    run_feed(TM, 1'b0, TM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mel_frame_sched.md
Name: mel_frame_sched

Overview:
- Run-level scheduler in front of and behind the MEL_SPEC front-end.
- On a start command it admits exactly the number of complex samples needed for N_FRAMES STFT frames into MEL_SPEC, throttled by buf_full.
- It then collects and tags the N_FRAMES*MEL_BANDS mel outputs with frame and band indices, and reports done or error status.
- Sits between the sample source / system control and the MEL_SPEC instance.

Parameters:
- WIDTH, 16, sample and mel data width.
- N_FRAMES, 101, frames per run.
- WIN_LEN, 480, window length in samples.
- HOP_LEN, 160, hop in samples.
- MEL_BANDS, 40, mel outputs per frame.
- DRAIN_TIMEOUT, 4096, idle cycles without mel_avail before timeout or flush completion.
- Derived: TOTAL_SAMPLES = WIN_LEN + (N_FRAMES-1)*HOP_LEN; TOTAL_MEL = N_FRAMES*MEL_BANDS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle run request
- abort  in  1  single-cycle run cancel
- src_valid  in  1  upstream sample valid
- src_ready  out  1  upstream sample accept
- src_re  in  WIDTH  upstream real sample
- src_im  in  WIDTH  upstream imaginary sample
- mel_signal_en  out  1  to MEL_SPEC signal_en
- mel_signal_re  out  WIDTH  to MEL_SPEC signal_re
- mel_signal_im  out  WIDTH  to MEL_SPEC signal_im
- mel_buf_full  in  1  from MEL_SPEC buf_full
- mel_avail  in  1  from MEL_SPEC mel_avail
- mel_data  in  WIDTH  from MEL_SPEC mel_data
- out_valid  out  1  tagged mel output strobe
- out_data  out  WIDTH  mel value
- out_frame  out  $clog2(N_FRAMES)  frame index
- out_band  out  $clog2(MEL_BANDS)  band index
- out_last  out  1  final mel value of run
- busy  out  1  state != IDLE
- done  out  1  single-cycle run-complete pulse
- err_timeout  out  1  sticky error flag
- err_spurious  out  1  sticky error flag

Behaviour:
- Reset:
  - state = IDLE; all counters = 0.
  - All outputs = 0: src_ready, mel_signal_*, out_*, busy, done, err_*.
- States: IDLE, FEED, DRAIN, DONE, FLUSH.
- IDLE:
  - start && !abort -> FEED.
  - start clears err_timeout and err_spurious and zeroes sample, band and frame counters.
  - start && abort in the same cycle: stay in IDLE, flags unchanged.
- FEED:
  - src_ready (combinational) = (state==FEED) && !mel_buf_full.
  - A transfer occurs on src_valid && src_ready.
  - Registered forward, 1-cycle latency: mel_signal_en = transfer; mel_signal_re/im = src_re/im, loaded only on a transfer.
  - sample_cnt increments per transfer.
  - The transfer with sample_cnt == TOTAL_SAMPLES-1 moves to DRAIN. No further samples are admitted.
- DRAIN: waits for the remaining mel outputs; src_ready = 0.
- Mel collection (FEED and DRAIN):
  - On mel_avail, next cycle: out_valid = 1, out_data = mel_data, out_band = band_cnt, out_frame = frame_cnt.
  - band_cnt wraps at MEL_BANDS-1 and increments frame_cnt on wrap.
  - out_last = 1 when frame_cnt == N_FRAMES-1 && band_cnt == MEL_BANDS-1. That same mel_avail moves to DONE, even from FEED.
- Timeout:
  - idle_cnt resets on every mel_avail and on entry to DRAIN; otherwise it increments in DRAIN.
  - idle_cnt == DRAIN_TIMEOUT-1 -> set err_timeout, go to DONE.
- DONE: done = 1 for exactly one cycle -> IDLE.
- Spurious outputs:
  - mel_avail in IDLE or DONE sets err_spurious.
  - The value is dropped: no out_valid.
- abort in FEED, DRAIN or DONE:
  - Go to FLUSH next cycle; src_ready = 0 immediately.
  - An in-flight registered mel_signal_en still completes.
- FLUSH:
  - mel_avail values are discarded silently (no error, no out_valid).
  - idle_cnt resets on mel_avail.
  - idle_cnt == DRAIN_TIMEOUT-1 -> IDLE, no done pulse.
  - start is ignored.
- start in any state other than IDLE is ignored.
- abort in IDLE is ignored.
- mel_buf_full deasserting resumes feeding on the same cycle; there is no bubble beyond the combinational ready.
- Counters:
  - sample_cnt width = $clog2(TOTAL_SAMPLES+1).
  - idle_cnt width = $clog2(DRAIN_TIMEOUT+1).
  - No arithmetic is performed on data; data is passed through unchanged.
- Mid-operation reset: identical to the power-up reset values on the next edge.

Test Plan:
- Params N_FRAMES=3, WIN_LEN=8, HOP_LEN=4, MEL_BANDS=4, DRAIN_TIMEOUT=32. Pulse start, keep src_valid=1, behavioural MEL_SPEC model -> exactly 16 mel_signal_en pulses. 12 out_valid with (frame,band) = (0,0)..(2,3). out_last only on (2,3). One done pulse the cycle after the last out_valid. err_* = 0.
- Hold mel_buf_full=1 for cycles 5-9 of FEED -> src_ready=0 and no mel_signal_en during those cycles. Still exactly 16 samples forwarded in total. Data order is preserved, checked against a src_re ramp 0..15.
- Model emits only 10 of 12 mel values -> after 32 idle DRAIN cycles err_timeout=1, done pulses, state returns to IDLE. The next start clears err_timeout.
- Assert abort after the 7th sample transfer, with the model emitting 2 late mel values -> no out_valid and no done. busy drops 32 cycles after the last mel_avail. A subsequent start completes a normal run.
- Pulse mel_avail while IDLE -> err_spurious=1, out_valid stays 0. start && abort together in IDLE -> state stays IDLE, err_spurious stays 1.
- Assert rst in DRAIN -> all outputs 0 the next cycle. A new start runs cleanly with frame and band counters starting at 0.
